// File: rtl/gbuff_loader_pkg.sv
// rtl/gbuff_loader_pkg.sv - shared widths and defaults for the gbuff loader slice
package gbuff_loader_pkg;

    localparam int GBUFF_IN_W        = 32;
    localparam int GBUFF_OUT_W       = 64;
    localparam int GBUFF_ADDR_W      = 10;
    localparam int GBUFF_LEN_W       = 10;
    localparam int GBUFF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/gbuff_rd_align.sv
// rtl/gbuff_rd_align.sv - aligns SRAM read data with the read strobe into the core's in_valid stream
module gbuff_rd_align
    import gbuff_loader_pkg::*;
#(
    parameter int IN_W = GBUFF_IN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [IN_W-1:0] a_rd_data,
    input  logic [IN_W-1:0] b_rd_data,
    output logic            in_valid,
    output logic [IN_W-1:0] gbuff_a,
    output logic [IN_W-1:0] gbuff_b,
    output logic            pending
);

    // rd_en_d1 marks the cycle the SRAM presents data; it is captured one cycle later.
    logic rd_en_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_d1 <= 1'b0;
            in_valid <= 1'b0;
            gbuff_a  <= '0;
            gbuff_b  <= '0;
        end else begin
            rd_en_d1 <= rd_en;
            in_valid <= rd_en_d1;
            if (rd_en_d1) begin
                gbuff_a <= a_rd_data;
                gbuff_b <= b_rd_data;
            end
        end
    end

    assign pending = rd_en_d1;

endmodule

// File: rtl/gbuff_loader.sv
// rtl/gbuff_loader.sv - feeds A/B gbuff lines to the core and stores its result lines
// LOADER_TIMEOUT_EN adds TIMEOUT_CYC and the err output (collect-phase watchdog).
module gbuff_loader
    import gbuff_loader_pkg::*;
#(
    parameter int IN_W   = GBUFF_IN_W,
    parameter int OUT_W  = GBUFF_OUT_W,
    parameter int ADDR_W = GBUFF_ADDR_W,
    parameter int LEN_W  = GBUFF_LEN_W
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = GBUFF_TIMEOUT_CYC
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  k_len,
    input  logic [LEN_W-1:0]  out_len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] o_base,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [IN_W-1:0]   a_rd_data,
    input  logic [IN_W-1:0]   b_rd_data,
    output logic              in_valid,
    output logic [IN_W-1:0]   gbuff_a,
    output logic [IN_W-1:0]   gbuff_b,
    input  logic              out_valid,
    input  logic [OUT_W-1:0]  gbuff_out,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [OUT_W-1:0]  o_wr_data,
    output logic              busy,
    output logic              done
`ifdef LOADER_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FEED    = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_FIN     = 2'd3;

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        state;
    logic [LEN_W-1:0]  k_len_r;
    logic [LEN_W-1:0]  out_len_r;
    logic [LEN_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] o_ptr;
    logic              rd_en;
    logic              pending;
    logic              accept;
    logic              wr_take;
    logic              collect_done;
    logic              timeout_hit;

    assign a_rd_en = rd_en;
    assign b_rd_en = rd_en;

    // The done cycle itself is treated as the tail of the job, so a start there is dropped.
    assign accept  = (state == S_IDLE) && start && !done;

    // Result lines are taken while feeding too, since the core may overlap its output.
    assign wr_take = out_valid && ((state == S_FEED) || (state == S_COLLECT))
                     && (wr_cnt != out_len_r);

    // Waiting on pending keeps done behind the last in_valid.
    assign collect_done = (wr_cnt == out_len_r) && !pending;

`ifdef LOADER_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = (state == S_COLLECT) && !out_valid && !collect_done && !pending
                         && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                err <= 1'b0;
            end else if (timeout_hit) begin
                err <= 1'b1;
            end
            if ((state != S_COLLECT) || out_valid) begin
                idle_cnt <= '0;
            end else if (!timeout_hit) begin
                idle_cnt <= idle_cnt + TO_ONE;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k_len_r   <= '0;
            out_len_r <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            o_ptr     <= '0;
            rd_en     <= 1'b0;
            a_rd_addr <= '0;
            b_rd_addr <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            o_wr_en <= 1'b0;

            if (wr_take) begin
                o_wr_en   <= 1'b1;
                o_wr_data <= gbuff_out;
                o_wr_addr <= o_ptr;
                o_ptr     <= o_ptr + ADDR_ONE;
                wr_cnt    <= wr_cnt + LEN_ONE;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        k_len_r   <= k_len;
                        out_len_r <= out_len;
                        o_ptr     <= o_base;
                        wr_cnt    <= '0;
                        busy      <= 1'b1;
                        if (k_len != '0) begin
                            state     <= S_FEED;
                            rd_en     <= 1'b1;
                            rd_cnt    <= LEN_ONE;
                            a_rd_addr <= a_base;
                            b_rd_addr <= b_base;
                        end else if (out_len != '0) begin
                            state <= S_COLLECT;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
                S_FEED: begin
                    // rd_cnt counts reads already issued, including the one on the bus now.
                    if (rd_cnt == k_len_r) begin
                        rd_en <= 1'b0;
                        state <= S_COLLECT;
                    end else begin
                        a_rd_addr <= a_rd_addr + ADDR_ONE;
                        b_rd_addr <= b_rd_addr + ADDR_ONE;
                        rd_cnt    <= rd_cnt + LEN_ONE;
                    end
                end
                S_COLLECT: begin
                    if (timeout_hit) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (collect_done) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    gbuff_rd_align #(
        .IN_W (IN_W)
    ) u_rd_align (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .a_rd_data (a_rd_data),
        .b_rd_data (b_rd_data),
        .in_valid  (in_valid),
        .gbuff_a   (gbuff_a),
        .gbuff_b   (gbuff_b),
        .pending   (pending)
    );

endmodule

// File: tb/tb_gbuff_loader.sv
// tb/tb_gbuff_loader.sv - directed self-checking bench for gbuff_loader
module tb_gbuff_loader;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int NLOG   = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  k_len = '0;
    logic [LEN_W-1:0]  out_len = '0;
    logic [ADDR_W-1:0] a_base = '0;
    logic [ADDR_W-1:0] b_base = '0;
    logic [ADDR_W-1:0] o_base = '0;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
    logic [IN_W-1:0]   a_rd_data = '0;
    logic [IN_W-1:0]   b_rd_data = '0;
    logic              in_valid;
    logic [IN_W-1:0]   gbuff_a, gbuff_b;
    logic              out_valid = 1'b0;
    logic [OUT_W-1:0]  gbuff_out = '0;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [OUT_W-1:0]  o_wr_data;
    logic              busy, done;
`ifdef LOADER_TIMEOUT_EN
    logic              err;
`endif

    always #5 clk = ~clk;

    gbuff_loader #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
`ifdef LOADER_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .out_len   (out_len),
        .a_base    (a_base),
        .b_base    (b_base),
        .o_base    (o_base),
        .a_rd_en   (a_rd_en),
        .b_rd_en   (b_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_addr (b_rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_data (b_rd_data),
        .in_valid  (in_valid),
        .gbuff_a   (gbuff_a),
        .gbuff_b   (gbuff_b),
        .out_valid (out_valid),
        .gbuff_out (gbuff_out),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .busy      (busy),
        .done      (done)
`ifdef LOADER_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    // SRAM models: A word = 0xA000|addr, B word = 0xB000|addr, one cycle read latency.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= 16'hA000 | 16'(a_rd_addr);
        if (b_rd_en) b_rd_data <= 16'hB000 | 16'(b_rd_addr);
    end

    logic              rd_log [NLOG];
    logic [ADDR_W-1:0] ra_log [NLOG];
    logic [ADDR_W-1:0] rb_log [NLOG];
    logic              iv_log [NLOG];
    logic [IN_W-1:0]   ga_log [NLOG];
    logic [IN_W-1:0]   gb_log [NLOG];
    logic              wr_log [NLOG];
    logic [ADDR_W-1:0] wa_log [NLOG];
    logic [OUT_W-1:0]  wd_log [NLOG];
    logic              done_log [NLOG];
    logic              busy_log [NLOG];
    logic              err_log [NLOG];
    logic              st_tbl [NLOG];
    logic              ov_tbl [NLOG];
    int                rst_at;
    int                n_rd, n_rdb, n_iv, n_wr, n_done;
    int                n_pass = 0;
    int                n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < NLOG; i++) begin
            st_tbl[i] = 1'b0;
            ov_tbl[i] = 1'b0;
        end
        rst_at = -1;
    endtask

    // Cycle r is the cycle after the r-th posedge of the job; start is high in cycle 0.
    task automatic run_job(input int k, input int ol, input int ab, input int bb, input int ob,
                           input int ncyc);
        n_rd = 0; n_rdb = 0; n_iv = 0; n_wr = 0; n_done = 0;
        for (int r = 0; r < ncyc; r++) begin
            @(posedge clk);
            #1;
            if (rst_at >= 0 && r == rst_at + 1) rst_n = 1'b1;
            start = (r == 0) || st_tbl[r];
            if (r == 0) begin
                k_len = LEN_W'(k); out_len = LEN_W'(ol);
                a_base = ADDR_W'(ab); b_base = ADDR_W'(bb); o_base = ADDR_W'(ob);
            end else begin
                k_len = 10'd5; out_len = 10'd3;
                a_base = 10'h155; b_base = 10'h155; o_base = 10'h155;
            end
            out_valid = ov_tbl[r];
            gbuff_out = 16'hC000 + 16'(r);
            if (r == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("async rst flags", {26'd0, a_rd_en, b_rd_en, in_valid, o_wr_en, busy, done}, 32'd0);
                check("async rst a_rd_addr", 32'(a_rd_addr), 32'd0);
                check("async rst gbuff_a", 32'(gbuff_a), 32'd0);
            end
            @(negedge clk);
            rd_log[r] = a_rd_en; ra_log[r] = a_rd_addr; rb_log[r] = b_rd_addr;
            iv_log[r] = in_valid; ga_log[r] = gbuff_a; gb_log[r] = gbuff_b;
            wr_log[r] = o_wr_en; wa_log[r] = o_wr_addr; wd_log[r] = o_wr_data;
            done_log[r] = done; busy_log[r] = busy;
`ifdef LOADER_TIMEOUT_EN
            err_log[r] = err;
`else
            err_log[r] = 1'b0;
`endif
            if (a_rd_en) n_rd++;
            if (b_rd_en) n_rdb++;
            if (in_valid) n_iv++;
            if (o_wr_en) n_wr++;
            if (done) n_done++;
        end
        start = 1'b0;
        out_valid = 1'b0;
    endtask

    logic [ADDR_W-1:0] exp_ra [4];
    logic [ADDR_W-1:0] exp_rb [4];
    logic [IN_W-1:0]   exp_ga [4];
    logic [IN_W-1:0]   exp_gb [4];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {26'd0, a_rd_en, b_rd_en, in_valid, o_wr_en, busy, done}, 32'd0);
        check("reset rd_addr", {a_rd_addr, b_rd_addr}, 32'd0);
        check("reset gbuff", {gbuff_a, gbuff_b}, 32'd0);
        check("reset o_wr", {o_wr_addr, o_wr_data}, 32'd0);
        rst_n = 1'b1;

        // Job 1: A base wraps past the top of the address space.
        clear_tbl();
        ov_tbl[10] = 1'b1; ov_tbl[12] = 1'b1;
        run_job(4, 2, 10'h3FE, 10'h010, 10'h100, 24);
        exp_ra = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        exp_rb = '{10'h010, 10'h011, 10'h012, 10'h013};
        exp_ga = '{16'hA3FE, 16'hA3FF, 16'hA000, 16'hA001};
        exp_gb = '{16'hB010, 16'hB011, 16'hB012, 16'hB013};
        check("t1 n_rd", n_rd, 4);
        check("t1 n_rdb", n_rdb, 4);
        check("t1 n_iv", n_iv, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1 rd_en", 32'(rd_log[1+i]), 1);
            check("t1 a_rd_addr", 32'(ra_log[1+i]), 32'(exp_ra[i]));
            check("t1 b_rd_addr", 32'(rb_log[1+i]), 32'(exp_rb[i]));
            check("t1 in_valid", 32'(iv_log[3+i]), 1);
            check("t1 gbuff_a", 32'(ga_log[3+i]), 32'(exp_ga[i]));
            check("t1 gbuff_b", 32'(gb_log[3+i]), 32'(exp_gb[i]));
        end
        check("t1 gbuff_a hold", 32'(ga_log[8]), 32'hA001);
        check("t1 n_wr", n_wr, 2);
        check("t1 wr0", {15'd0, wr_log[11], wa_log[11], wd_log[11]}, {15'd0, 1'b1, 10'h100, 16'hC00A});
        check("t1 wr1", {15'd0, wr_log[13], wa_log[13], wd_log[13]}, {15'd0, 1'b1, 10'h101, 16'hC00C});
        check("t1 n_done", n_done, 1);
        check("t1 done cycle", 32'(done_log[15]), 1);
        check("t1 busy", {28'd0, busy_log[0], busy_log[1], busy_log[14], busy_log[15]}, 32'b0110);

        // Job 2: empty job.
        clear_tbl();
        run_job(0, 0, 10'h000, 10'h000, 10'h000, 8);
        check("t2 done cycle", 32'(done_log[2]), 1);
        check("t2 n_done", n_done, 1);
        check("t2 n_rd n_wr", n_rd + n_wr, 0);
        check("t2 busy", {30'd0, busy_log[1], busy_log[2]}, 32'b10);

        // Job 3: writes overlap the feed, extras dropped, output address wraps.
        clear_tbl();
        ov_tbl[2] = 1'b1; ov_tbl[3] = 1'b1; ov_tbl[4] = 1'b1; ov_tbl[9] = 1'b1; ov_tbl[10] = 1'b1;
        run_job(3, 2, 10'h100, 10'h200, 10'h3FF, 16);
        check("t3 n_wr", n_wr, 2);
        check("t3 wr0", {15'd0, wr_log[3], wa_log[3], wd_log[3]}, {15'd0, 1'b1, 10'h3FF, 16'hC002});
        check("t3 wr1", {15'd0, wr_log[4], wa_log[4], wd_log[4]}, {15'd0, 1'b1, 10'h000, 16'hC003});
        check("t3 n_iv", n_iv, 3);
        check("t3 last gbuff_a", 32'(ga_log[5]), 32'hA102);
        check("t3 done cycle", 32'(done_log[7]), 1);
        check("t3 n_done", n_done, 1);

        // Job 4a: start during FIN and during the done cycle.
        clear_tbl();
        st_tbl[1] = 1'b1; st_tbl[2] = 1'b1;
        run_job(0, 0, 10'h000, 10'h000, 10'h000, 8);
        check("t4a n_done", n_done, 1);
        check("t4a n_rd", n_rd, 0);
        check("t4a busy after", {29'd0, busy_log[3], busy_log[5], busy_log[7]}, 32'd0);

        // Job 4b: start while feeding, in FIN and in the done cycle.
        clear_tbl();
        st_tbl[2] = 1'b1; st_tbl[8] = 1'b1; st_tbl[9] = 1'b1;
        ov_tbl[6] = 1'b1;
        run_job(2, 1, 10'h020, 10'h040, 10'h080, 16);
        check("t4b n_rd", n_rd, 2);
        check("t4b addrs", {ra_log[1], ra_log[2]}, {10'h020, 10'h021});
        check("t4b wr0", {15'd0, wr_log[7], wa_log[7], wd_log[7]}, {15'd0, 1'b1, 10'h080, 16'hC006});
        check("t4b done cycle", 32'(done_log[9]), 1);
        check("t4b n_done", n_done, 1);
        check("t4b busy after", {30'd0, busy_log[10], busy_log[12]}, 32'd0);

        // Job 5: reset in the middle of the feed, then a clean job.
        clear_tbl();
        rst_at = 3;
        ov_tbl[6] = 1'b1;
        run_job(6, 1, 10'h050, 10'h060, 10'h000, 12);
        check("t5 n_rd", n_rd, 2);
        check("t5 n_iv", n_iv, 0);
        check("t5 n_wr", n_wr, 0);
        check("t5 n_done", n_done, 0);
        check("t5 busy end", 32'(busy_log[11]), 0);
        clear_tbl();
        ov_tbl[5] = 1'b1;
        run_job(1, 1, 10'h3FF, 10'h000, 10'h010, 12);
        check("t5b rd", {21'd0, rd_log[1], ra_log[1]}, {21'd0, 1'b1, 10'h3FF});
        check("t5b gbuff", {iv_log[3] ? 16'h0001 : 16'h0000, ga_log[3]}, {16'h0001, 16'hA3FF});
        check("t5b gbuff_b", 32'(gb_log[3]), 32'hB000);
        check("t5b wr0", {15'd0, wr_log[6], wa_log[6], wd_log[6]}, {15'd0, 1'b1, 10'h010, 16'hC005});
        check("t5b done cycle", 32'(done_log[8]), 1);
        check("t5b n_done", n_done, 1);

`ifdef LOADER_TIMEOUT_EN
        // Job 6: no results arrive; watchdog ends the job, next start clears err.
        clear_tbl();
        run_job(2, 1, 10'h000, 10'h000, 10'h000, 30);
        check("t6 err before", 32'(err_log[18]), 0);
        check("t6 done cycle", 32'(done_log[19]), 1);
        check("t6 n_done", n_done, 1);
        check("t6 err set", {30'd0, err_log[19], err_log[29]}, 32'b11);
        check("t6 busy", 32'(busy_log[19]), 0);
        clear_tbl();
        run_job(0, 0, 10'h000, 10'h000, 10'h000, 4);
        check("t6 err held", 32'(err_log[0]), 1);
        check("t6 err cleared", 32'(err_log[1]), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
